duty_ramp_ctrl: RTL and testbench
=================================

DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter: SYS_CLK_FREQ, 100_000_000, clk frequency in Hz, used to derive the 1 ms tick.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  level input; the rising edge is detected internally and requests a ramp.
REQ-005 SHALL have port: stop  input  1  level input; the rising edge is detected internally and requests a graceful ramp-down.
REQ-006 SHALL have port: cont  input  1  1 = continuous breathing, 0 = single up/hold/down sequence.
REQ-007 SHALL have port: step_ms  input  8  ms per 1-unit duty step; 0 is treated as 1.
REQ-008 SHALL have port: hold_ms  input  10  ms held at each ramp end; 0 means no hold state.
REQ-009 SHALL have port: duty_max  input  7  ramp ceiling in percent; values >100 are clamped to 100.
REQ-010 SHALL have port: duty  output  7  registered duty command (0..100) for the downstream 100-step PWM generator.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: done  output  1  one-clk pulse when the ramp returns to IDLE.

Function
REQ-013 SHALL generate a one-clk ms_tick every SYS_CLK_FREQ/1000 clocks from a free-running prescaler that runs in all states.
REQ-014 SHALL implement the FSM states IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-015 SHALL, in IDLE, on a start edge, latch clamped duty_max into ceil_r, clear the step counter and enter UP.
REQ-016 SHALL, in UP, increment duty by 1 after step_ms ms_ticks; on reaching duty==ceil_r, enter HOLD_HI (or DOWN if hold_ms==0).
REQ-017 SHALL, in HOLD_HI, leave the state after hold_ms ms_ticks and enter DOWN.
REQ-018 SHALL, in DOWN, decrement duty by 1 after step_ms ms_ticks; on reaching duty==0, enter HOLD_LO if cont=1 and hold_ms!=0, else UP if cont=1, else IDLE with done.
REQ-019 SHALL, in HOLD_LO, enter UP after hold_ms ms_ticks.
REQ-020 SHALL sample step_ms and hold_ms at the start of each step/hold interval; changes mid-interval take effect on the next interval.
REQ-021 SHALL ignore start edges while busy=1.
REQ-022 SHALL, on a stop edge in UP/HOLD_HI/HOLD_LO, enter DOWN from the current duty and then go to IDLE with done at duty==0, regardless of cont.
REQ-023 SHALL, on a stop edge in DOWN, force the current descent to terminate in IDLE; stop edges in IDLE are ignored.
REQ-024 SHALL give stop priority when start and stop edges occur in the same cycle: in IDLE nothing happens, otherwise REQ-022 applies.
REQ-025 SHALL, if ceil_r==0, pass through UP directly into the hold/down path with duty held at 0, then to IDLE with done, producing no UP steps.
REQ-026 SHALL keep duty monotonic within a state and never exceed ceil_r or drop below 0; no wrap-around.
REQ-027 SHALL register duty one clk after the FSM step event; done is asserted in the same cycle busy falls.

Reset
REQ-028 SHALL, on reset_n low, immediately force state=IDLE, duty=0, busy=0, done=0 and clear the prescaler, step/hold counters, ceil_r and the edge-detector history.
REQ-029 SHALL, on reset mid-ramp, abandon the ramp without emitting done.
REQ-030 SHALL, after reset release, require a fresh start rising edge; a start held high through reset does not trigger.

Configuration
REQ-031 SHALL, when DUTY_RAMP_GAMMA_EN is defined, drive duty = (lin*lin+50)/100, where lin is the linear ramp value (0→0, 50→25, 100→100), through one extra register stage, giving total latency of 2 clk from the step event.
REQ-032 SHALL, when DUTY_RAMP_GAMMA_EN is undefined, drive duty = lin with the latency of REQ-027; FSM timing is identical in both builds.

Verification
REQ-033 SHALL verify: SYS_CLK_FREQ=1000 (1-clk tick), cont=0, step_ms=2, hold_ms=3, duty_max=4, start pulse -> duty 0,1,2,3,4 every 2 ticks, held 3 ticks, 3..0, then one done pulse and busy low.
REQ-034 SHALL verify: duty_max=120 -> duty peaks at 100 and never exceeds it.
REQ-035 SHALL verify: cont=1, stop edge when duty=3 in UP -> duty descends 2,1,0 then done; start edges during the ramp are ignored.
REQ-036 SHALL verify: reset_n pulsed low while duty=2 -> duty=0 and busy=0 asynchronously, no done; start held high after release -> no ramp.
REQ-037 SHALL verify: duty_max=0 -> start produces busy, then done, with duty held at 0 throughout.
REQ-038 SHALL verify: DUTY_RAMP_GAMMA_EN defined, lin=50 -> duty=25; lin=100 -> duty=100, one clk later than in the linear build.

Source files
------------

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: ms-paced up/hold/down duty sequencer feeding a 100-step PWM.
// Define DUTY_RAMP_GAMMA_EN for a squared output curve with one extra register stage.
module duty_ramp_ctrl #(
    parameter int SYS_CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [7:0] step_ms,
    input  logic [9:0] hold_ms,
    input  logic [6:0] duty_max,
    output logic [6:0] duty,
    output logic       busy,
    output logic       done
);
    localparam int DIV = (SYS_CLK_FREQ / 1000 < 1) ? 1 : SYS_CLK_FREQ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic          start_q, stop_q, armed_q, stopping_q, busy_q, done_q;
    logic [9:0]    cnt_q, len_q;
    logic [6:0]    ceil_q, lin_q;
    logic          ms_tick, start_edge, stop_edge, last_tick, at_ceil, at_floor, hold_nz;
    logic [9:0]    step_len;
    logic [6:0]    ceil_d;

    assign ms_tick    = (pre_q == PW'(DIV - 1));
    // armed_q masks the first cycle after reset so a level held through reset is not an edge
    assign start_edge = armed_q & start & ~start_q;
    assign stop_edge  = armed_q & stop & ~stop_q;
    assign last_tick  = ms_tick & (cnt_q + 10'd1 == len_q);
    assign step_len   = (step_ms == 8'd0) ? 10'd1 : {2'b00, step_ms};
    assign ceil_d     = (duty_max > 7'd100) ? 7'd100 : duty_max;
    assign at_ceil    = (lin_q == ceil_q);
    assign at_floor   = (lin_q == 7'd0);
    assign hold_nz    = (hold_ms != 10'd0);
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pre_q <= '0;
        else pre_q <= ms_tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            armed_q    <= 1'b0;
            stopping_q <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            ceil_q     <= '0;
            lin_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            if (ms_tick) cnt_q <= cnt_q + 10'd1;
            case (state_q)
                IDLE: if (start_edge && !stop_edge) begin
                    ceil_q     <= ceil_d;
                    lin_q      <= '0;
                    stopping_q <= 1'b0;
                    cnt_q      <= '0;
                    len_q      <= step_len;
                    busy_q     <= 1'b1;
                    state_q    <= UP;
                end
                UP: if (stop_edge) begin
                    stopping_q <= 1'b1;
                    cnt_q      <= '0;
                    len_q      <= step_len;
                    state_q    <= DOWN;
                end else if (at_ceil || last_tick) begin
                    // at_ceil on entry only happens for a zero ceiling: skip straight past UP
                    cnt_q <= '0;
                    if (!at_ceil) lin_q <= lin_q + 7'd1;
                    if (at_ceil || lin_q + 7'd1 == ceil_q) begin
                        len_q   <= hold_nz ? hold_ms : step_len;
                        state_q <= hold_nz ? HOLD_HI : DOWN;
                    end else begin
                        len_q <= step_len;
                    end
                end
                HOLD_HI, HOLD_LO: if (stop_edge) begin
                    stopping_q <= 1'b1;
                    cnt_q      <= '0;
                    len_q      <= step_len;
                    state_q    <= DOWN;
                end else if (last_tick) begin
                    cnt_q   <= '0;
                    len_q   <= step_len;
                    state_q <= (state_q == HOLD_HI) ? DOWN : UP;
                end
                DOWN: begin
                    if (stop_edge) stopping_q <= 1'b1;
                    if (at_floor || last_tick) begin
                        cnt_q <= '0;
                        len_q <= step_len;
                        if (!at_floor) lin_q <= lin_q - 7'd1;
                        if (lin_q <= 7'd1) begin
                            if (stopping_q || stop_edge || !cont) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else if (hold_nz) begin
                                len_q   <= hold_ms;
                                state_q <= HOLD_LO;
                            end else begin
                                state_q <= UP;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DUTY_RAMP_GAMMA_EN
    logic [13:0] sq;
    logic [6:0]  duty_q;

    assign sq   = 14'(lin_q) * 14'(lin_q) + 14'd50;
    assign duty = duty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) duty_q <= '0;
        else duty_q <= 7'(sq / 14'd100);
    end
`else
    assign duty = lin_q;
`endif

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb_duty_ramp_ctrl: randomized ramps checked cycle by cycle against a trace built from the ramp rules.
module tb_duty_ramp_ctrl;
    localparam int P_UP = 0, P_HH = 1, P_DN = 2, P_HL = 3;
`ifdef DUTY_RAMP_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [7:0] step_ms = '0;
    logic [9:0] hold_ms = '0;
    logic [6:0] duty_max = '0;
    logic [6:0] duty;
    logic       busy, done;
    int         n_chk = 0, n_pass = 0;
    int         e_lin[$];
    int         e_ph[$];

    duty_ramp_ctrl #(.SYS_CLK_FREQ(1000)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .cont(cont),
        .step_ms(step_ms), .hold_ms(hold_ms), .duty_max(duty_max),
        .duty(duty), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int out_map(int v);
        return GAMMA ? (v * v + 50) / 100 : v;
    endfunction

    task automatic push(int ph, int v, int n);
        repeat (n) begin
            e_ph.push_back(ph);
            e_lin.push_back(v);
        end
    endtask

    // one entry per clock while busy (1 ms tick per clock): phase and linear duty level
    task automatic build(int cl, int s, int h, bit c, int maxlen);
        e_lin.delete();
        e_ph.delete();
        do begin
            if (cl == 0) push(P_UP, 0, 1);
            else for (int v = 0; v < cl; v++) push(P_UP, v, s);
            if (h != 0) push(P_HH, cl, h);
            if (cl == 0) push(P_DN, 0, 1);
            else for (int v = cl; v >= 1; v--) push(P_DN, v, s);
            if (c && h != 0) push(P_HL, 0, h);
        end while (c && e_lin.size() < maxlen);
    endtask

    // stop edge seen on the clock after entry k
    task automatic apply_stop(int k, int s);
        int p, d, j;
        p = e_ph[k];
        d = e_lin[k];
        j = k + 1;
        if (p == P_DN) while (j < e_lin.size() && e_ph[j] == P_DN) j++;
        while (e_lin.size() > j) begin
            void'(e_lin.pop_back());
            void'(e_ph.pop_back());
        end
        if (p != P_DN) begin
            if (d == 0) push(P_DN, 0, 1);
            else for (int v = d; v >= 1; v--) push(P_DN, v, s);
        end
    endtask

    task automatic run_scn(int st, int hd, int dm, bit c, int k, bit poke);
        int cl, s, n, mx, dn, prev;
        cl = (dm > 100) ? 100 : dm;
        s  = (st == 0) ? 1 : st;
        build(cl, s, hd, c, 60);
        if (k == -2) k = $urandom_range(0, e_lin.size() - 1);
        if (k >= 0) apply_stop(k, s);
        n = e_lin.size();
        @(negedge clk);
        step_ms = 8'(st); hold_ms = 10'(hd); duty_max = 7'(dm); cont = c;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mx = 0; dn = 0; prev = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("duty[%0d]", i), duty, out_map(GAMMA ? prev : e_lin[i]));
            check($sformatf("busy[%0d]", i), busy, 1);
            if (done) dn++;
            if (duty > mx) mx = duty;
            prev = e_lin[i];
            stop  = (i == k);
            start = (poke && i + 3 < n) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        check("end_duty", duty, out_map(GAMMA ? prev : 0));
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        if (done) dn++;
        stop = 1'b0;
        @(negedge clk);
        check("idle_duty", duty, 0);
        check("idle_busy", busy, 0);
        if (done) dn++;
        check("done_cnt", dn, 1);
        if (k < 0) check("peak", mx, out_map(cl));
    endtask

    initial begin
        int st, hd, dm, r;
        bit c;
        repeat (2) @(negedge clk);
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_scn(2, 3, 4, 1'b0, -1, 1'b0);
        run_scn(0, 1, 120, 1'b0, -1, 1'b0);
        run_scn(1, 0, 100, 1'b0, -1, 1'b0);
        run_scn(2, 2, 6, 1'b1, 6, 1'b1);
        run_scn(1, 2, 0, 1'b0, -1, 1'b0);
        run_scn(3, 0, 0, 1'b0, -1, 1'b0);
        run_scn(1, 1, 3, 1'b1, -2, 1'b1);

        // stop alone, then start with stop, while idle: both ignored
        @(negedge clk); stop = 1'b1;
        repeat (3) begin @(negedge clk); check("idle_stop_busy", busy, 0); end
        stop = 1'b0; start = 1'b0;
        @(negedge clk); start = 1'b1; stop = 1'b1;
        repeat (3) begin @(negedge clk); check("start_stop_busy", busy, 0); end
        start = 1'b0; stop = 1'b0;

        // reset mid-ramp at duty 2, start held high through release
        @(negedge clk);
        step_ms = 8'd1; hold_ms = 10'd1; duty_max = 7'd5; cont = 1'b0;
        @(negedge clk); start = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_duty", duty, out_map(GAMMA ? 1 : 2));
        #2 reset_n = 1'b0;
        #1;
        check("async_duty", duty, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_busy[%0d]", i), busy, 0);
            check($sformatf("post_rst_done[%0d]", i), done, 0);
        end
        start = 1'b0;

        for (int t = 0; t < 25; t++) begin
            st = $urandom_range(0, 3);
            hd = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            dm = (r < 7) ? $urandom_range(0, 6) : (r < 9) ? $urandom_range(1, 12) : $urandom_range(95, 127);
            c  = 1'($urandom_range(0, 1));
            run_scn(st, hd, dm, c, (c || $urandom_range(0, 1) == 1) ? -2 : -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
